// File: rtl/syscall_console_ctrl_if.sv
// rtl/syscall_console_ctrl_if.sv - decoder and console signal bundle for syscall_console_ctrl
interface syscall_console_ctrl_if;
    logic        req;
    logic [31:0] ID;
    logic [31:0] rs;
    logic [31:0] rt1;
    logic [31:0] rt2;
    logic [31:0] rt3;
    logic [31:0] rt4;
    logic        busy;
    logic        done;
    logic        err;
    logic        halted;
    logic        con_valid;
    logic        con_ready;
    logic [1:0]  con_type;
    logic [31:0] con_data;

    modport master (
        output req, ID, rs, rt1, rt2, rt3, rt4, con_ready,
        input  busy, done, err, halted, con_valid, con_type, con_data
    );

    modport slave (
        input  req, ID, rs, rt1, rt2, rt3, rt4, con_ready,
        output busy, done, err, halted, con_valid, con_type, con_data
    );
endinterface

// File: rtl/syscall_console_ctrl.sv
// rtl/syscall_console_ctrl.sv - syscall sequencer emitting one integer or char per console handshake
module syscall_console_ctrl #(
    parameter logic [31:0] SYSCALL_ID = 32'd26,
    parameter int          NWORDS     = 4
) (
    input  logic               clk,
    input  logic               reset,
    syscall_console_ctrl_if.slave bus
);
    localparam int IDXW = $clog2(4 * NWORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EMIT = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]      state;
    logic            done_q;
    logic            err_q;
    logic            halted_q;
    logic            is_str;
    logic [1:0]      ctype;
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] last_idx;
    logic [31:0]     words [NWORDS];

    logic [31:0]     cur_word;
    logic [7:0]      cur_byte;
    logic            nul_char;

    // Chars are packed MSB-first within each word.
    always_comb begin
        cur_word = words[idx[IDXW-1:2]];
        cur_byte = 8'h00;
        case (idx[1:0])
            2'd0:    cur_byte = cur_word[31:24];
            2'd1:    cur_byte = cur_word[23:16];
            2'd2:    cur_byte = cur_word[15:8];
            default: cur_byte = cur_word[7:0];
        endcase
    end

    assign nul_char = is_str && (cur_byte == 8'h00);

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.halted    = halted_q;
    assign bus.con_valid = (state == EMIT) && !nul_char;
    assign bus.con_type  = (state == EMIT) ? ctype : 2'd0;
    assign bus.con_data  = (state != EMIT) ? 32'd0 :
                           is_str          ? {24'd0, cur_byte} : words[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
            is_str   <= 1'b0;
            ctype    <= 2'd0;
            idx      <= '0;
            last_idx <= '0;
            for (int i = 0; i < NWORDS; i++) words[i] <= 32'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req && (bus.ID == SYSCALL_ID)) begin
                        words[0] <= bus.rt1;
                        words[1] <= bus.rt2;
                        words[2] <= bus.rt3;
                        words[3] <= bus.rt4;
                        idx      <= '0;
                        // rs 4..7 carries rs-3 words, so the last char index is {rs[1:0], 2'b11}.
                        last_idx <= IDXW'({bus.rs[1:0], 2'b11});
                        case (bus.rs)
                            32'd1: begin
                                state  <= EMIT;
                                is_str <= 1'b0;
                                ctype  <= 2'd1;
                            end
                            32'd8: begin
                                state  <= EMIT;
                                is_str <= 1'b0;
                                ctype  <= 2'd2;
                            end
                            32'd4, 32'd5, 32'd6, 32'd7: begin
                                state  <= EMIT;
                                is_str <= 1'b1;
                                ctype  <= 2'd0;
                            end
                            32'd3: done_q <= 1'b1;
                            32'd2: begin
                                state    <= HALT;
                                halted_q <= 1'b1;
                                done_q   <= 1'b1;
                            end
                            default: begin
                                err_q  <= 1'b1;
                                done_q <= 1'b1;
                            end
                        endcase
                    end
                end
                EMIT: begin
                    if (nul_char) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end else if (bus.con_ready) begin
                        if (!is_str || (idx == last_idx)) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                HALT:    halted_q <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_syscall_console_ctrl.sv
// tb/tb_syscall_console_ctrl.sv - directed self-checking bench for syscall_console_ctrl
module tb_syscall_console_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    syscall_console_ctrl_if bus ();

    syscall_console_ctrl #(.SYSCALL_ID(32'd26), .NWORDS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Presents one request for a single posedge; returns at the negedge after acceptance.
    task automatic issue(input logic [31:0] id, input logic [31:0] code,
                         input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] w3, input logic [31:0] w4);
        bus.req = 1'b1;
        bus.ID  = id;
        bus.rs  = code;
        bus.rt1 = w1;
        bus.rt2 = w2;
        bus.rt3 = w3;
        bus.rt4 = w4;
        step();
        bus.req = 1'b0;
    endtask

    initial begin
        int  k;
        logic rdy;
        reset         = 1'b0;
        bus.req       = 1'b0;
        bus.ID        = 32'd0;
        bus.rs        = 32'd0;
        bus.rt1       = 32'd0;
        bus.rt2       = 32'd0;
        bus.rt3       = 32'd0;
        bus.rt4       = 32'd0;
        bus.con_ready = 1'b0;
        step();
        step();
        chk("rst_busy",   {31'd0, bus.busy},      32'd0);
        chk("rst_done",   {31'd0, bus.done},      32'd0);
        chk("rst_err",    {31'd0, bus.err},       32'd0);
        chk("rst_halted", {31'd0, bus.halted},    32'd0);
        chk("rst_valid",  {31'd0, bus.con_valid}, 32'd0);
        chk("rst_type",   {30'd0, bus.con_type},  32'd0);
        chk("rst_data",   bus.con_data,           32'd0);
        reset = 1'b1;
        step();

        // signed integer
        bus.con_ready = 1'b1;
        issue(32'd26, 32'd1, 32'hFFFFFC17, 32'd0, 32'd0, 32'd0);
        chk("int_valid", {31'd0, bus.con_valid}, 32'd1);
        chk("int_type",  {30'd0, bus.con_type},  32'd1);
        chk("int_data",  bus.con_data,           32'hFFFFFC17);
        chk("int_busy",  {31'd0, bus.busy},      32'd1);
        chk("int_done0", {31'd0, bus.done},      32'd0);
        step();
        chk("int_done",  {31'd0, bus.done},      32'd1);
        chk("int_idle",  {31'd0, bus.busy},      32'd0);
        chk("int_vld0",  {31'd0, bus.con_valid}, 32'd0);
        step();
        chk("int_done1w", {31'd0, bus.done},     32'd0);

        // unsigned integer
        issue(32'd26, 32'd8, 32'hFFFFFC17, 32'd0, 32'd0, 32'd0);
        chk("uint_type", {30'd0, bus.con_type},  32'd2);
        chk("uint_data", bus.con_data,           32'd4294966295);
        step();
        chk("uint_done", {31'd0, bus.done},      32'd1);

        // 16-char string at full rate
        issue(32'd26, 32'd7, 32'h41424344, 32'h45464748, 32'h494A4B4C, 32'h4D4E4F50);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("s16_valid%0d", i), {31'd0, bus.con_valid}, 32'd1);
            chk($sformatf("s16_data%0d", i),  bus.con_data, 32'h41 + i);
            step();
        end
        chk("s16_done", {31'd0, bus.done},      32'd1);
        chk("s16_busy", {31'd0, bus.busy},      32'd0);
        chk("s16_vld",  {31'd0, bus.con_valid}, 32'd0);

        // 8-char string with alternating ready
        bus.con_ready = 1'b0;
        issue(32'd26, 32'd5, 32'h41424344, 32'h45464748, 32'h0, 32'h0);
        k   = 0;
        rdy = 1'b0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            bus.con_ready = rdy;
            chk($sformatf("tog_valid%0d", c), {31'd0, bus.con_valid}, 32'd1);
            chk($sformatf("tog_data%0d", c),  bus.con_data, 32'h41 + k);
            if (rdy) k++;
            rdy = ~rdy;
            step();
        end
        chk("tog_count", k, 32'd8);
        chk("tog_done", {31'd0, bus.done}, 32'd1);

        // NUL-terminated string
        bus.con_ready = 1'b1;
        issue(32'd26, 32'd6, 32'h41424344, 32'h45460000, 32'h494A4B4C, 32'h0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("nul_data%0d", i), bus.con_data, 32'h41 + i);
            step();
        end
        chk("nul_vld",   {31'd0, bus.con_valid}, 32'd0);
        chk("nul_busy",  {31'd0, bus.busy},      32'd1);
        chk("nul_done0", {31'd0, bus.done},      32'd0);
        step();
        chk("nul_done",  {31'd0, bus.done},      32'd1);
        chk("nul_idle",  {31'd0, bus.busy},      32'd0);

        // nop
        issue(32'd26, 32'd3, 32'd5, 32'd0, 32'd0, 32'd0);
        chk("nop_done", {31'd0, bus.done},      32'd1);
        chk("nop_busy", {31'd0, bus.busy},      32'd0);
        chk("nop_vld",  {31'd0, bus.con_valid}, 32'd0);

        // unknown service
        issue(32'd26, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("bad_err",  {31'd0, bus.err},  32'd1);
        chk("bad_done", {31'd0, bus.done}, 32'd1);
        step();
        chk("bad_err1w", {31'd0, bus.err}, 32'd0);

        // non-syscall ID ignored
        issue(32'd14, 32'd1, 32'd7, 32'd0, 32'd0, 32'd0);
        chk("id_busy", {31'd0, bus.busy},      32'd0);
        chk("id_vld",  {31'd0, bus.con_valid}, 32'd0);
        chk("id_done", {31'd0, bus.done},      32'd0);

        // reset mid-string
        issue(32'd26, 32'd7, 32'h41424344, 32'h45464748, 32'h494A4B4C, 32'h4D4E4F50);
        step();
        chk("mid_data", bus.con_data, 32'h42);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid_vld",  {31'd0, bus.con_valid}, 32'd0);
        chk("mid_busy", {31'd0, bus.busy},      32'd0);
        chk("mid_cdat", bus.con_data,           32'd0);
        step();

        // exit, then halted absorbs requests
        issue(32'd26, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("halt_flag", {31'd0, bus.halted}, 32'd1);
        chk("halt_done", {31'd0, bus.done},   32'd1);
        chk("halt_busy", {31'd0, bus.busy},   32'd1);
        issue(32'd26, 32'd1, 32'd3, 32'd0, 32'd0, 32'd0);
        chk("halt_vld",   {31'd0, bus.con_valid}, 32'd0);
        chk("halt_done1", {31'd0, bus.done},      32'd0);
        chk("halt_keep",  {31'd0, bus.halted},    32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("unhalt_flag", {31'd0, bus.halted}, 32'd0);
        chk("unhalt_busy", {31'd0, bus.busy},   32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/syscall_console_ctrl.md
Name: syscall_console_ctrl

Overview:
- Sequences syscall service requests from the decode/execute stage onto a single-item console output channel.
- Captures the service code (rs) and argument words (rt1..rt4) when a syscall (ID==SYSCALL_ID) is issued.
- Emits one integer or one character per handshake, stalls the pipeline while emitting, and latches a sticky halt on the exit service.
- Sits between the instruction decoder outputs and the console/display model in system_top.

Parameters:
- SYSCALL_ID, 26, decoded instruction ID that identifies a syscall.
- NWORDS, 4, number of argument words; max string length is 4*NWORDS chars.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-low reset.
- req  input  1  decoded instruction valid this cycle.
- ID  input  32  decoded instruction ID.
- rs  input  32  syscall service code.
- rt1, rt2, rt3, rt4  input  32 each  argument words; string chars packed MSB-first, so "ABCD" gives 'A' in [31:24].
- busy  output  1  stall request to the pipeline.
- done  output  1  one-cycle pulse when a syscall completes.
- err  output  1  one-cycle pulse for an unknown service code.
- halted  output  1  sticky; set by the exit service.
- con_valid  output  1  console item valid.
- con_ready  input  1  console accepts the item.
- con_type  output  2  item type: 0 char, 1 signed int, 2 unsigned int.
- con_data  output  32  item payload; chars are zero-extended bytes.

Behaviour:
- Reset:
  - Takes effect when reset==0 at a posedge; overrides everything, including mid-emission.
  - State goes to IDLE; busy, done, err, halted, con_valid, con_type, con_data all 0.
- States: IDLE, EMIT, HALT. busy = (state != IDLE), registered.
- IDLE: acts only when req==1 and ID==SYSCALL_ID; any other req is ignored with no output change. On acceptance, latch rs and rt1..rt4, then decode rs:
  - 1: one item, type 1, data rt1 -> EMIT.
  - 8: one item, type 2, data rt1 -> EMIT.
  - 4, 5, 6, 7: string of (rs-3) words = 4*(rs-3) chars, char index idx=0 -> EMIT.
  - 3: nop. done=1 next cycle, stay IDLE, busy stays 0.
  - 2: exit -> HALT. halted=1 and done=1 in the next cycle.
  - Any other code: err=1 and done=1 next cycle, stay IDLE.
- EMIT:
  - con_valid=1 while in EMIT, except when the current char is NUL (below).
  - con_type and con_data are held stable until con_valid && con_ready; they must not change while not ready.
  - Integer item: handshake -> IDLE, done=1 next cycle.
  - String char selection: word = idx[3:2], byte = 3 - idx[1:0]. con_data = {24'b0, byte}.
  - Each handshake increments idx.
  - On the handshake of the last char (idx == 4*(rs-3)-1) -> IDLE with done.
  - NUL terminator: if the current selected byte is 0x00, con_valid=0 and the next posedge goes -> IDLE with done. NUL is never emitted.
  - req is ignored throughout EMIT; upstream holds the instruction under busy.
- HALT:
  - Absorbing: all req ignored, busy=1, halted=1.
  - Left only by reset.
- Latency:
  - Request accepted at edge T gives con_valid high after T.
  - With con_ready=1, an n-char string completes in n cycles, and done pulses in the cycle after the last handshake.
  - Back-to-back throughput is 1 item/cycle.
- done and err are exactly one cycle wide. Only one syscall is in flight at a time.

Test Plan:
- rs=1, rt1=-1001, con_ready=1 -> one transfer type=1 data=32'hFFFFFC17, busy for 1 cycle, done pulse, then back to IDLE.
- rs=8, rt1=-1001 -> one transfer type=2 data=32'hFFFFFC17 (4294966295 unsigned).
- rs=7, rt1..rt4="ABCD","EFGH","IJKL","MNOP", con_ready=1 -> 16 consecutive chars 0x41..0x50, then done.
- rs=5, "ABCD"/"EFGH", con_ready toggling every cycle -> 8 chars A..H, data stable while not ready, no duplicates or drops.
- rs=6, rt2="EF\0\0" -> chars A B C D E F only, then done; no NUL emitted; busy drops.
- Control services:
  - rs=3 -> done with no con_valid.
  - rs=9 -> err+done.
  - ID=14 with req -> ignored.
  - rs=2 -> halted=1, and a following rs=1 request produces no output.
  - reset=0 for one edge clears halted.
  - reset=0 pulsed mid-string -> con_valid=0 next cycle, IDLE.
